// File: rtl/jump_resolve_queue_if.sv
// jump_resolve_queue_if
// Groups the fetch-side prediction push channel, the execute-side resolve
// channel and the table-update / fetch-redirect outputs of the jump resolve
// queue into one bundle.
//   pred_*      : prediction record pushed at fetch (pred_ready back-pressure)
//   exe_*       : resolution of the oldest in-flight jump
//   flush       : squash every in-flight record
//   upd_*       : write port of the fetch-stage jump history table
//   redirect*   : fetch restart request and target
// master = fetch/execute/table side, slave = the queue itself.
interface jump_resolve_queue_if;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_hit;
   logic [31:0] pred_target;
   logic        pred_ready;

   logic        exe_valid;
   logic [31:0] exe_pc;
   logic [31:0] exe_target;
   logic        flush;

   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_dest;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output pred_valid, pred_pc, pred_hit, pred_target,
      output exe_valid, exe_pc, exe_target, flush,
      input  pred_ready,
      input  upd_valid, upd_pc, upd_dest, redirect, redirect_pc
   );

   modport slave (
      input  pred_valid, pred_pc, pred_hit, pred_target,
      input  exe_valid, exe_pc, exe_target, flush,
      output pred_ready,
      output upd_valid, upd_pc, upd_dest, redirect, redirect_pc
   );
endinterface

// File: rtl/jump_resolve_queue.sv
// jump_resolve_queue
// Execute-side counterpart of the fetch-stage jump history table. Every jump
// predicted at fetch leaves a {pc, hit, target} record here; when execute
// resolves the oldest jump the record is compared against the real outcome.
// A wrong or missing prediction writes the table, redirects fetch and throws
// away all younger (wrong-path) records.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   jq (slave)   : prediction push, resolve, flush, table update, redirect
//   count        : occupied entries
//   resolve_cnt  : number of accepted resolves (wraps)
//   miss_cnt     : number of mispredicts (wraps)
//   order_err    : sticky, a resolve did not match the head record's pc
module jump_resolve_queue #(
   parameter int DEPTH    = 8,
   parameter int CNT_BITS = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   jump_resolve_queue_if.slave          jq,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_BITS-1:0]          resolve_cnt,
   output logic [CNT_BITS-1:0]          miss_cnt,
   output logic                         order_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [31:0]   pc_mem  [DEPTH];
   logic          hit_mem [DEPTH];
   logic [31:0]   tgt_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic          empty;
   logic [31:0]   head_pc;
   logic          head_hit;
   logic [31:0]   head_target;
   logic          resolve_now;
   logic          mispredict_now;
   logic          pop_now;
   logic          push_now;
   logic          order_bad;

   // Ready only looks at the current occupancy; a pop in the same cycle does
   // not free a slot early, which keeps this path short.
   assign jq.pred_ready = (count != FULL_COUNT);

   // Decode what happens this cycle. Flush wins over everything. A mispredict
   // blocks the push because the incoming record is on the wrong path, and an
   // empty-queue resolve counts as a jump the table never predicted.
   always_comb begin
      empty          = (count == '0);
      head_pc        = pc_mem[rd_ptr];
      head_hit       = hit_mem[rd_ptr];
      head_target    = tgt_mem[rd_ptr];
      resolve_now    = 1'b0;
      mispredict_now = 1'b0;
      pop_now        = 1'b0;
      push_now       = 1'b0;
      order_bad      = 1'b0;

      resolve_now = jq.exe_valid && !jq.flush;
      if (resolve_now) begin
         if (empty) begin
            mispredict_now = 1'b1;
         end else begin
            pop_now        = 1'b1;
            order_bad      = (head_pc != jq.exe_pc);
            mispredict_now = !head_hit || (head_target != jq.exe_target) || order_bad;
         end
      end
      push_now = jq.pred_valid && jq.pred_ready && !jq.flush && !mispredict_now;
   end

   // Pointers and occupancy. Flush and mispredict both empty the queue and
   // re-base the pointers to zero; otherwise push and pop advance independently
   // and count only moves when exactly one of them happens.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (jq.flush || mispredict_now) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_now) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_now) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_now && !pop_now) begin
            count <= count + CW'(1);
         end else if (pop_now && !push_now) begin
            count <= count - CW'(1);
         end
      end
   end

   // Record storage. Contents need no reset because count gates every read
   // that matters.
   always_ff @(posedge clk) begin
      if (push_now) begin
         pc_mem[wr_ptr]  <= jq.pred_pc;
         hit_mem[wr_ptr] <= jq.pred_hit;
         tgt_mem[wr_ptr] <= jq.pred_target;
      end
   end

   // Table update and fetch redirect, registered so each is a one-cycle pulse
   // one clock after the resolving exe_valid. Data fields hold their last
   // value between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jq.upd_valid   <= 1'b0;
         jq.upd_pc      <= '0;
         jq.upd_dest    <= '0;
         jq.redirect    <= 1'b0;
         jq.redirect_pc <= '0;
      end else begin
         jq.upd_valid <= mispredict_now;
         jq.redirect  <= mispredict_now;
         if (mispredict_now) begin
            jq.upd_pc      <= jq.exe_pc;
            jq.upd_dest    <= jq.exe_target;
            jq.redirect_pc <= jq.exe_target;
         end
      end
   end

   // Performance counters and the sticky ordering error flag. A flushed
   // resolve is not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resolve_cnt <= '0;
         miss_cnt    <= '0;
         order_err   <= 1'b0;
      end else begin
         if (resolve_now) begin
            resolve_cnt <= resolve_cnt + CNT_BITS'(1);
         end
         if (mispredict_now) begin
            miss_cnt <= miss_cnt + CNT_BITS'(1);
         end
         if (order_bad) begin
            order_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jump_resolve_queue.sv
// tb_jump_resolve_queue
// Directed bench for jump_resolve_queue: correct hit, miss record, wrong
// target with younger records, full/wrap ordering, flush against resolve,
// empty resolve, ordering error and asynchronous reset mid-operation.
module tb_jump_resolve_queue;

   localparam int DEPTH    = 8;
   localparam int CNT_BITS = 16;

   logic                        clk;
   logic                        reset;
   logic [$clog2(DEPTH+1)-1:0]  count;
   logic [CNT_BITS-1:0]         resolve_cnt;
   logic [CNT_BITS-1:0]         miss_cnt;
   logic                        order_err;

   int checks;
   int errors;

   jump_resolve_queue_if jq ();

   jump_resolve_queue #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
      .clk         (clk),
      .reset       (reset),
      .jq          (jq),
      .count       (count),
      .resolve_cnt (resolve_cnt),
      .miss_cnt    (miss_cnt),
      .order_err   (order_err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_idle();
      jq.pred_valid  = 1'b0;
      jq.pred_pc     = '0;
      jq.pred_hit    = 1'b0;
      jq.pred_target = '0;
      jq.exe_valid   = 1'b0;
      jq.exe_pc      = '0;
      jq.exe_target  = '0;
      jq.flush       = 1'b0;
   endtask

   // Drives one cycle of inputs, lets the edge happen, samples 1 ns later
   // with the inputs back at idle.
   task automatic applyStimulus(input logic pv, input logic [31:0] ppc,
                                input logic phit, input logic [31:0] ptgt,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] etgt, input logic fl);
      jq.pred_valid  = pv;
      jq.pred_pc     = ppc;
      jq.pred_hit    = phit;
      jq.pred_target = ptgt;
      jq.exe_valid   = ev;
      jq.exe_pc      = epc;
      jq.exe_target  = etgt;
      jq.flush       = fl;
      @(posedge clk);
      #1;
      drive_idle();
   endtask

   task automatic do_push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
      applyStimulus(1'b1, pc, hit, tgt, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic do_resolve(input logic [31:0] pc, input logic [31:0] tgt);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, tgt, 1'b0);
   endtask

   task automatic do_idle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_count",     count,          0);
      checkOutput("rst_ready",     jq.pred_ready,  1);
      checkOutput("rst_upd_valid", jq.upd_valid,   0);
      checkOutput("rst_redirect",  jq.redirect,    0);
      checkOutput("rst_resolve",   resolve_cnt,    0);
      checkOutput("rst_miss",      miss_cnt,       0);
      checkOutput("rst_order",     order_err,      0);
      checkOutput("rst_redir_pc",  jq.redirect_pc, 0);
      reset = 1'b0;
      do_idle();

      // Correct hit: pop only, no pulse.
      do_push(32'h1000, 1'b1, 32'h2000);
      checkOutput("hit_count_push", count, 1);
      do_resolve(32'h1000, 32'h2000);
      checkOutput("hit_count_pop", count,       0);
      checkOutput("hit_upd_valid", jq.upd_valid, 0);
      checkOutput("hit_redirect",  jq.redirect,  0);
      checkOutput("hit_resolve",   resolve_cnt,  1);
      checkOutput("hit_miss",      miss_cnt,     0);

      // Miss record: table update and redirect one cycle after exe_valid.
      do_push(32'h1000, 1'b0, 32'h0);
      do_resolve(32'h1000, 32'h2000);
      checkOutput("miss_upd_valid", jq.upd_valid,   1);
      checkOutput("miss_upd_pc",    jq.upd_pc,      32'h1000);
      checkOutput("miss_upd_dest",  jq.upd_dest,    32'h2000);
      checkOutput("miss_redirect",  jq.redirect,    1);
      checkOutput("miss_redir_pc",  jq.redirect_pc, 32'h2000);
      checkOutput("miss_miss",      miss_cnt,       1);
      checkOutput("miss_resolve",   resolve_cnt,    2);
      checkOutput("miss_count",     count,          0);
      do_idle();
      checkOutput("miss_pulse_end_upd", jq.upd_valid, 0);
      checkOutput("miss_pulse_end_red", jq.redirect,  0);

      // Wrong target with younger records and a same-cycle push.
      do_push(32'h1000, 1'b1, 32'h2000);
      do_push(32'h1010, 1'b1, 32'h2010);
      do_push(32'h1020, 1'b1, 32'h2020);
      checkOutput("wt_count3", count, 3);
      applyStimulus(1'b1, 32'h1030, 1'b1, 32'h2030, 1'b1, 32'h1000, 32'h3000, 1'b0);
      checkOutput("wt_redirect", jq.redirect,    1);
      checkOutput("wt_redir_pc", jq.redirect_pc, 32'h3000);
      checkOutput("wt_count0",   count,          0);
      checkOutput("wt_miss",     miss_cnt,       2);
      do_idle();
      checkOutput("wt_push_dropped", count, 0);

      // Fill to DEPTH, overflow push ignored, drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         do_push(32'h8000 + 32'(i * 4), 1'b1, 32'h9000 + 32'(i * 4));
      end
      checkOutput("full_count", count,         DEPTH);
      checkOutput("full_ready", jq.pred_ready, 0);
      do_push(32'hDEAD0000, 1'b1, 32'hBEEF0000);
      checkOutput("full_9th_ignored", count, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         do_resolve(32'h8000 + 32'(i * 4), 32'h9000 + 32'(i * 4));
         checkOutput("drain1_redirect", jq.redirect, 0);
      end
      checkOutput("drain1_count",   count,       0);
      checkOutput("drain1_miss",    miss_cnt,    2);
      checkOutput("drain1_resolve", resolve_cnt, 11);

      // Second fill, partial drain, push+pop together, refill across the wrap.
      for (int i = 0; i < DEPTH; i++) begin
         do_push(32'hA000 + 32'(i * 4), 1'b1, 32'hA800 + 32'(i * 4));
      end
      for (int i = 0; i < 3; i++) begin
         do_resolve(32'hA000 + 32'(i * 4), 32'hA800 + 32'(i * 4));
      end
      checkOutput("wrap_count5", count, 5);
      applyStimulus(1'b1, 32'hB000, 1'b1, 32'hB800, 1'b1, 32'hA00C, 32'hA80C, 1'b0);
      checkOutput("wrap_pushpop_count", count,       5);
      checkOutput("wrap_pushpop_red",   jq.redirect, 0);
      for (int i = 1; i < 4; i++) begin
         do_push(32'hB000 + 32'(i * 4), 1'b1, 32'hB800 + 32'(i * 4));
      end
      checkOutput("wrap_refill_count", count, DEPTH);
      for (int i = 4; i < DEPTH; i++) begin
         do_resolve(32'hA000 + 32'(i * 4), 32'hA800 + 32'(i * 4));
         checkOutput("wrap_drainA_redirect", jq.redirect, 0);
      end
      for (int i = 0; i < 4; i++) begin
         do_resolve(32'hB000 + 32'(i * 4), 32'hB800 + 32'(i * 4));
         checkOutput("wrap_drainB_redirect", jq.redirect, 0);
      end
      checkOutput("wrap_count0",  count,       0);
      checkOutput("wrap_miss",    miss_cnt,    2);
      checkOutput("wrap_resolve", resolve_cnt, 23);
      checkOutput("wrap_order",   order_err,   0);

      // Flush together with a (mismatching) resolve and a push.
      do_push(32'hC000, 1'b1, 32'hC800);
      do_push(32'hC004, 1'b1, 32'hC804);
      checkOutput("flush_count2", count, 2);
      applyStimulus(1'b1, 32'hC008, 1'b1, 32'hC808, 1'b1, 32'hC000, 32'hC100, 1'b1);
      checkOutput("flush_count0",  count,        0);
      checkOutput("flush_upd",     jq.upd_valid, 0);
      checkOutput("flush_red",     jq.redirect,  0);
      checkOutput("flush_resolve", resolve_cnt,  23);
      checkOutput("flush_miss",    miss_cnt,     2);

      // Resolve with nothing queued is an unpredicted jump.
      do_resolve(32'h4000, 32'h5000);
      checkOutput("empty_red",      jq.redirect,    1);
      checkOutput("empty_upd",      jq.upd_valid,   1);
      checkOutput("empty_upd_pc",   jq.upd_pc,      32'h4000);
      checkOutput("empty_redir_pc", jq.redirect_pc, 32'h5000);
      checkOutput("empty_resolve",  resolve_cnt,    24);
      checkOutput("empty_miss",     miss_cnt,       3);
      checkOutput("empty_count",    count,          0);

      // Resolved pc differs from head pc: sticky order error plus redirect.
      do_push(32'h1000, 1'b1, 32'h2000);
      do_resolve(32'h1004, 32'h2000);
      checkOutput("order_err_set", order_err,   1);
      checkOutput("order_red",     jq.redirect, 1);
      checkOutput("order_upd_pc",  jq.upd_pc,   32'h1004);
      do_idle();
      checkOutput("order_err_sticky", order_err, 1);

      // Asynchronous reset with records in flight.
      for (int i = 0; i < 5; i++) begin
         do_push(32'hE000 + 32'(i * 4), 1'b1, 32'hE800 + 32'(i * 4));
      end
      checkOutput("prereset_count", count, 5);
      reset = 1'b1;
      #2;
      checkOutput("areset_order", order_err,     0);
      checkOutput("areset_count", count,         0);
      checkOutput("areset_ready", jq.pred_ready, 1);
      checkOutput("areset_miss",  miss_cnt,      0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      do_idle();
      checkOutput("postreset_upd",   jq.upd_valid, 0);
      checkOutput("postreset_red",   jq.redirect,  0);
      checkOutput("postreset_count", count,        0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
